// File: rtl/alu_rcl_seq_pkg.sv
// Shared definitions for the iterative rotate-left-through-carry unit:
// widths, ring lengths, FSM state codes and the result payload.
package alu_rcl_seq_pkg;

    localparam int unsigned W      = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned RING_W = 17;
    localparam int unsigned RING_B = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [W-1:0] r;
        logic         cout;
        logic         ovf;
    } rsp_t;

    // A rotation by the ring length is the identity, so only the remainder matters.
    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] cnt,
                                                   input logic             word);
        if (word)
            return CNT_W'(32'(cnt) % RING_W);
        else
            return CNT_W'(32'(cnt) % RING_B);
    endfunction

endpackage

// File: rtl/alu_rcl_seq_if.sv
// Request/response bundle between the ALU sequencer and the RCL unit.
interface alu_rcl_seq_if;

    logic                                start;
    logic [alu_rcl_seq_pkg::W-1:0]       A;
    logic                                Cin;
    logic [alu_rcl_seq_pkg::CNT_W-1:0]   count;
    logic                                w;
    logic                                busy;
    logic                                done;
    logic [alu_rcl_seq_pkg::W-1:0]       R;
    logic                                Cout;
    logic                                OF;

    modport master (
        output start, A, Cin, count, w,
        input  busy, done, R, Cout, OF
    );

    modport slave (
        input  start, A, Cin, count, w,
        output busy, done, R, Cout, OF
    );

endinterface

// File: rtl/alu_rcl_seq_rcl_step.sv
// One-bit rotate-left-through-carry of {c,d}: 17-bit ring in word mode,
// 9-bit ring over d[7:0] in byte mode (upper byte forced to zero).
module rcl_step
    import alu_rcl_seq_pkg::*;
(
    input  logic [W-1:0] d,
    input  logic         c,
    input  logic         w,
    output logic [W-1:0] q,
    output logic         co
);

    always_comb begin
        q  = '0;
        co = 1'b0;
        if (w) begin
            co = d[W-1];
            q  = {d[W-2:0], c};
        end else begin
            co = d[BYTE_W-1];
            q  = {{(W-BYTE_W){1'b0}}, d[BYTE_W-2:0], c};
        end
    end

endmodule

// File: rtl/alu_rcl_seq.sv
// Iterative RCL unit: one ring step per clock, start/busy/done handshake.
// Build option ALU_RCL_MOD_REDUCE_EN reduces the count modulo the ring length at load.
module alu_rcl_seq
    import alu_rcl_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_rcl_seq_if.slave bus
);

    state_t           state, state_nx;
    logic [W-1:0]     d_q, d_nx, step_d;
    logic             c_q, c_nx, step_c;
    logic [CNT_W-1:0] n_q, n_nx;
    logic             w_q, w_nx;
    logic             c1_q, c1_nx;
    logic             busy_q, busy_nx;
    logic             done_q, done_nx;
    rsp_t             rsp_q, rsp_nx;
    logic             msb;

    rcl_step u_step (
        .d  (d_q),
        .c  (c_q),
        .w  (w_q),
        .q  (step_d),
        .co (step_c)
    );

    assign msb = w_q ? d_q[W-1] : d_q[BYTE_W-1];

    // Next-state, datapath and output-register next values.
    always_comb begin
        state_nx = state;
        d_nx     = d_q;
        c_nx     = c_q;
        n_nx     = n_q;
        w_nx     = w_q;
        c1_nx    = c1_q;
        rsp_nx   = rsp_q;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_RUN;
                    d_nx     = bus.w ? bus.A : {{(W-BYTE_W){1'b0}}, bus.A[BYTE_W-1:0]};
                    c_nx     = bus.Cin;
                    w_nx     = bus.w;
                    c1_nx    = (bus.count == CNT_W'(1));
`ifdef ALU_RCL_MOD_REDUCE_EN
                    n_nx     = eff_count(bus.count, bus.w);
`else
                    n_nx     = bus.count;
`endif
                end
            end
            ST_RUN: begin
                if (n_q != '0) begin
                    d_nx = step_d;
                    c_nx = step_c;
                    n_nx = n_q - CNT_W'(1);
                end else begin
                    state_nx    = ST_FIN;
                    rsp_nx.r    = d_q;
                    rsp_nx.cout = c_q;
                    rsp_nx.ovf  = c1_q & (msb ^ c_q);
                end
            end
            ST_FIN: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx == ST_RUN);
        done_nx = (state_nx == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            d_q    <= '0;
            c_q    <= 1'b0;
            n_q    <= '0;
            w_q    <= 1'b0;
            c1_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rsp_q  <= '0;
        end else begin
            state  <= state_nx;
            d_q    <= d_nx;
            c_q    <= c_nx;
            n_q    <= n_nx;
            w_q    <= w_nx;
            c1_q   <= c1_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
            rsp_q  <= rsp_nx;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.R    = rsp_q.r;
    assign bus.Cout = rsp_q.cout;
    assign bus.OF   = rsp_q.ovf;

endmodule
